// File: rtl/wb_arbiter_stage.sv
// rtl/wb_arbiter_stage.sv - MEM/WB register with late-result FIFO sharing the register-file write port
module wb_arbiter_stage #(
    parameter int XLEN       = 32,
    parameter int NSRC       = 5,
    parameter int SELW       = 3,
    parameter int LATE_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_m,
    input  logic                 reg_write_m,
    input  logic [SELW-1:0]      result_src_m,
    input  logic [4:0]           rd_m,
    input  logic [NSRC*XLEN-1:0] src_data_m,
    output logic                 stall_o,
    input  logic                 late_valid,
    output logic                 late_ready,
    input  logic [4:0]           late_rd,
    input  logic [XLEN-1:0]      late_data,
    output logic                 we3,
    output logic [4:0]           a3,
    output logic [XLEN-1:0]      wd3,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic [31:0]          late_busy
);

    localparam int PTRW = (LATE_DEPTH > 1) ? $clog2(LATE_DEPTH) : 1;
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(LATE_DEPTH);

    logic            wb_valid_q, wb_valid_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic [4:0]      fifo_rd_q   [LATE_DEPTH];
    logic [4:0]      fifo_rd_d   [LATE_DEPTH];
    logic [XLEN-1:0] fifo_data_q [LATE_DEPTH];
    logic [XLEN-1:0] fifo_data_d [LATE_DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;

    logic            fifo_full, fifo_empty, pipe_req, late_sel, push, pop;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     busy_c;

    always_comb begin
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        pipe_req   = wb_valid_q & wb_reg_write_q & (wb_rd_q != 5'd0);
        // Late results preempt the pipeline only when they have nowhere else to wait.
        late_sel   = ~fifo_empty & (~pipe_req | fifo_full);
        pop        = late_sel;
        stall_o    = fifo_full & pipe_req;
        late_ready = ~fifo_full;
        push       = late_valid & late_ready & (late_rd != 5'd0);
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (result_src_m == SELW'(k)) begin
                sel_data = src_data_m[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        wb_valid_d     = wb_valid_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        if (!stall_o) begin
            wb_valid_d     = valid_m;
            wb_reg_write_d = reg_write_m;
            wb_rd_d        = rd_m;
            wb_data_d      = sel_data;
        end
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = late_rd;
            fifo_data_d[wr_ptr_q] = late_data;
            wr_ptr_d              = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        we3 = 1'b0;
        a3  = 5'd0;
        wd3 = '0;
        if (late_sel) begin
            we3 = 1'b1;
            a3  = fifo_rd_q[rd_ptr_q];
            wd3 = fifo_data_q[rd_ptr_q];
        end else if (pipe_req) begin
            we3 = 1'b1;
            a3  = wb_rd_q;
            wd3 = wb_data_q;
        end
        fwd_valid = we3;
        fwd_rd    = a3;
        fwd_data  = wd3;
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin : busy_calc
        logic [PTRW-1:0] off;
        off    = '0;
        busy_c = '0;
        for (int i = 0; i < LATE_DEPTH; i++) begin
            off = PTRW'(i) - rd_ptr_q;
            if (CNTW'(off) < count_q) begin
                busy_c[fifo_rd_q[i]] = 1'b1;
            end
        end
        late_busy = busy_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            for (int i = 0; i < LATE_DEPTH; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            fifo_rd_q      <= fifo_rd_d;
            fifo_data_q    <= fifo_data_d;
        end
    end

endmodule
